// File: rtl/request_holder.sv
`default_nettype none
// ============================================================================
//  Module      : request_holder
//  Description : Front end of the 4-way arbiter. Turns single-cycle request
//                pulses into level requests backed by per-client pending
//                counters, retires one request per valid grant, and raises
//                overflow, starvation and illegal-grant flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module request_holder #(
    parameter int NUM_REQ      = 4,
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_pulse_i,
    input  logic [NUM_REQ-1:0]       grant_i,
    output logic [NUM_REQ-1:0]       request_o,
    output logic [NUM_REQ*CNT_W-1:0] pending_cnt_o,
    output logic [NUM_REQ-1:0]       overflow_o,
    output logic [NUM_REQ-1:0]       starve_o,
    output logic                     grant_err_o
);

    localparam int                  c_WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(STARVE_LIMIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [NUM_REQ-1:0]  c_REQ_ONE  = NUM_REQ'(1);

    // Registered state
    logic [NUM_REQ-1:0][CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0][c_WAIT_W-1:0] r_wait;
    logic [NUM_REQ-1:0]               r_ovf;
    logic [NUM_REQ-1:0]               r_starve;
    logic                             r_grant_err;

    // Decoded / combinational helpers
    logic [NUM_REQ-1:0] w_request;
    logic               w_grant_any;
    logic               w_grant_onehot;
    logic               w_grant_multi;
    logic               w_grant_unreq;
    logic [NUM_REQ-1:0] w_retire;

    // Level request is a pure decode of the pending counters, so it only
    // moves on a clock edge and never follows an input combinationally.
    genvar gk;
    generate
        for (gk = 0; gk < NUM_REQ; gk++) begin : g_req_decode
            assign w_request[gk] = (r_cnt[gk] != '0);
        end
    endgenerate

    // A grant is usable only when exactly one line is set; a multi-bit grant
    // is treated as garbage and retires nothing anywhere.
    assign w_grant_any    = |grant_i;
    assign w_grant_onehot = w_grant_any && ((grant_i & (grant_i - c_REQ_ONE)) == '0);
    assign w_grant_multi  = w_grant_any && !w_grant_onehot;
    assign w_grant_unreq  = |(grant_i & ~w_request);
    assign w_retire       = w_grant_onehot ? (grant_i & w_request) : '0;

    // Pending counters, sticky overflow, wait counters and starvation flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_wait   <= '0;
            r_ovf    <= '0;
            r_starve <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // A pulse coinciding with a retire cancels out; a pulse into a
                // full counter is dropped and recorded. Retire cannot underflow
                // because it requires a nonzero count.
                case ({req_pulse_i[k], w_retire[k]})
                    2'b10: begin
                        if (r_cnt[k] == c_CNT_MAX) begin
                            r_ovf[k] <= 1'b1;
                        end else begin
                            r_cnt[k] <= r_cnt[k] + c_CNT_ONE;
                        end
                    end
                    2'b01:   r_cnt[k] <= r_cnt[k] - c_CNT_ONE;
                    default: r_cnt[k] <= r_cnt[k];
                endcase

                // Wait time restarts whenever the client is idle or served.
                if (!w_request[k] || w_retire[k]) begin
                    r_wait[k] <= '0;
                end else if (r_wait[k] != c_WAIT_MAX) begin
                    r_wait[k] <= r_wait[k] + c_WAIT_ONE;
                end

                // Flag follows the wait counter by one cycle.
                r_starve[k] <= (r_wait[k] == c_WAIT_MAX);
            end
        end
    end

    // Illegal grant: more than one line, or a line for an idle client
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_err <= 1'b0;
        end else begin
            r_grant_err <= w_grant_multi | w_grant_unreq;
        end
    end

    assign request_o     = w_request;
    assign pending_cnt_o = r_cnt;
    assign overflow_o    = r_ovf;
    assign starve_o      = r_starve;
    assign grant_err_o   = r_grant_err;

endmodule
`default_nettype wire

// File: tb/tb_request_holder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_request_holder
//  Description : Directed bench for request_holder. Stimulus pushes the
//                expected post-edge state into a queue; a monitor pops and
//                compares on the falling edge of the matching cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_request_holder;

    logic        clk;
    logic        rst;
    logic [3:0]  req_pulse_i;
    logic [3:0]  grant_i;
    logic [3:0]  request_o;
    logic [11:0] pending_cnt_o;
    logic [3:0]  overflow_o;
    logic [3:0]  starve_o;
    logic        grant_err_o;

    request_holder #(
        .NUM_REQ      (4),
        .CNT_W        (3),
        .STARVE_LIMIT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_pulse_i   (req_pulse_i),
        .grant_i       (grant_i),
        .request_o     (request_o),
        .pending_cnt_o (pending_cnt_o),
        .overflow_o    (overflow_o),
        .starve_o      (starve_o),
        .grant_err_o   (grant_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          cycle;
        logic [3:0]  req;
        logic [11:0] cnt;
        logic [3:0]  ovf;
        logic [3:0]  stv;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Hand-tracked expected state
    int         e_cnt [4];
    logic [3:0] e_ovf;
    logic [3:0] e_starve;
    logic       e_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record the expected state after the edge that just happened
    task automatic chk(input string name);
        exp_t e;
        e.name  = name;
        e.cycle = cyc;
        for (int k = 0; k < 4; k++) begin
            e.req[k]          = (e_cnt[k] != 0);
            e.cnt[k*3 +: 3]   = 3'(e_cnt[k]);
        end
        e.ovf = e_ovf;
        e.stv = e_starve;
        e.err = e_err;
        q.push_back(e);
    endtask

    // Monitor: compare each queued expectation on its own cycle
    exp_t m_e;
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cycle <= cyc) begin
            m_e = q.pop_front();
            checks++;
            if (m_e.cycle != cyc || request_o !== m_e.req || pending_cnt_o !== m_e.cnt ||
                overflow_o !== m_e.ovf || starve_o !== m_e.stv || grant_err_o !== m_e.err) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d got req=%b cnt=%h ovf=%b starve=%b err=%b required req=%b cnt=%h ovf=%b starve=%b err=%b",
                         m_e.name, cyc, m_e.cycle, request_o, pending_cnt_o, overflow_o, starve_o,
                         grant_err_o, m_e.req, m_e.cnt, m_e.ovf, m_e.stv, m_e.err);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        req_pulse_i = 4'b0000;
        grant_i     = 4'b0000;
        for (int k = 0; k < 4; k++) e_cnt[k] = 0;
        e_ovf    = 4'b0000;
        e_starve = 4'b0000;
        e_err    = 1'b0;

        // 1. Reset state
        tick(); chk("reset_1");
        tick(); chk("reset_2");
        rst = 1'b0;

        // 2. Single pulse then single grant on client 0
        req_pulse_i = 4'b0001;
        tick(); e_cnt[0] = 1; chk("t2_pulse");
        req_pulse_i = 4'b0000; grant_i = 4'b0001;
        tick(); e_cnt[0] = 0; chk("t2_retire");
        grant_i = 4'b0000;
        tick(); chk("t2_idle");

        // 3. Eight pulses on client 2: saturate at 7, sticky overflow
        req_pulse_i = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            e_cnt[2] = (i + 1 > 7) ? 7 : i + 1;
            if (i == 7) e_ovf[2] = 1'b1;
            chk("t3_fill");
        end
        req_pulse_i = 4'b0000; grant_i = 4'b0100;
        for (int j = 1; j <= 7; j++) begin
            tick(); e_cnt[2] = 7 - j; chk("t3_drain");
        end
        grant_i = 4'b0000;
        tick(); chk("t3_ovf_sticky");

        // 4. Pulse+grant cancel at count 2; multi-bit grant; idle-client grant
        req_pulse_i = 4'b0010;
        tick(); e_cnt[1] = 1; chk("t4_cnt1");
        tick(); e_cnt[1] = 2; chk("t4_cnt2");
        grant_i = 4'b0010;
        tick(); chk("t4_pulse_and_grant");
        req_pulse_i = 4'b0000; grant_i = 4'b0110;
        tick(); e_err = 1'b1; chk("t4_multi_grant");
        grant_i = 4'b0000;
        tick(); e_err = 1'b0; chk("t4_err_pulse_end");
        grant_i = 4'b0010;
        tick(); e_cnt[1] = 1; chk("t4_drain1");
        tick(); e_cnt[1] = 0; chk("t4_drain0");
        grant_i = 4'b0001;
        tick(); e_err = 1'b1; chk("t4_unreq_grant");
        grant_i = 4'b0000;
        tick(); e_err = 1'b0; chk("t4_unreq_end");

        // 5. Client 3 starvation and recovery
        req_pulse_i = 4'b1000;
        tick(); e_cnt[3] = 1; chk("t5_pulse");
        req_pulse_i = 4'b0000;
        for (int k = 1; k <= 17; k++) begin
            tick(); e_starve[3] = (k >= 16); chk("t5_wait");
        end
        grant_i = 4'b1000;
        tick(); e_cnt[3] = 0; e_starve[3] = 1'b1; chk("t5_grant");
        grant_i = 4'b0000;
        tick(); e_starve[3] = 1'b0; chk("t5_starve_clear");

        // 6. Build counts 3,1,0,2 then reset mid-stream
        req_pulse_i = 4'b1011;
        tick(); e_cnt[0] = 1; e_cnt[1] = 1; e_cnt[3] = 1; chk("t6_load1");
        req_pulse_i = 4'b1001;
        tick(); e_cnt[0] = 2; e_cnt[3] = 2; chk("t6_load2");
        req_pulse_i = 4'b0001;
        tick(); e_cnt[0] = 3; chk("t6_load3");
        rst = 1'b1; req_pulse_i = 4'b1111; grant_i = 4'b0001;
        tick();
        for (int k = 0; k < 4; k++) e_cnt[k] = 0;
        e_ovf = 4'b0000;
        chk("t6_reset");
        rst = 1'b0; req_pulse_i = 4'b0000; grant_i = 4'b0000;
        tick(); chk("t6_after_reset");

        // Let the monitor drain its queue, bounded
        for (int w = 0; w < 20 && q.size() != 0; w++) tick();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
